prf_freelist: RTL and testbench

PRF_FREELIST -- requirements
Module: prf_freelist

---
 rtl/prf_freelist_if.sv | 23 ++
 rtl/prf_freelist.sv | 81 ++++++++
 tb/tb_prf_freelist.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/prf_freelist_if.sv
// Rename/retire-facing bus of the physical register free list.
// The master side (rename and retire logic) drives requests; the slave side is the free list.
interface prf_freelist_if;
  logic       retire_transmit;
  logic [3:0] retire_id;
  logic       alloc_req;
  logic       alloc_valid;
  logic [3:0] alloc_id;
  logic [4:0] free_count;
  logic [15:0] alloc_vec;
  logic       overflow_err;
  logic       dup_free_err;

  modport master (
    output retire_transmit, retire_id, alloc_req,
    input  alloc_valid, alloc_id, free_count, alloc_vec, overflow_err, dup_free_err
  );

  modport slave (
    input  retire_transmit, retire_id, alloc_req,
    output alloc_valid, alloc_id, free_count, alloc_vec, overflow_err, dup_free_err
  );
endinterface

// File: rtl/prf_freelist.sv
// Physical register free list: 16-entry circular FIFO of free ids with a show-ahead grant.
// Optional macro PRF_FREELIST_DUP_CHECK_EN drops frees of ids that are not currently allocated.
module prf_freelist #(
  parameter int RESET_FREE_BASE = 8
) (
  input logic            clk,
  input logic            rst,
  prf_freelist_if.slave  bus
);

  localparam logic [15:0] RESET_VEC  = 16'((32'h1 << RESET_FREE_BASE) - 32'h1);
  localparam logic [3:0]  RESET_TAIL = 4'((16 - RESET_FREE_BASE) % 16);
  localparam logic [4:0]  RESET_CNT  = 5'(16 - RESET_FREE_BASE);

  logic [3:0]  fifo [16];
  logic [3:0]  head;
  logic [3:0]  tail;
  logic [4:0]  count;
  logic [15:0] alloc_vec;
  logic [15:0] vec_next;
  logic        overflow_err;
  logic        dup_free_err;
  logic        full;
  logic        grant;
  logic        dup_ok;
  logic        dup_drop;
  logic        free_ok;

`ifdef PRF_FREELIST_DUP_CHECK_EN
  assign dup_ok = alloc_vec[bus.retire_id];
`else
  assign dup_ok = 1'b1;
`endif

  assign full     = (count == 5'd16);
  assign grant    = bus.alloc_req && (count != 5'd0);
  assign free_ok  = bus.retire_transmit && !full && dup_ok;
  assign dup_drop = bus.retire_transmit && !full && !dup_ok;

  // Free is applied after the grant so a same-id grant+free leaves the bit clear.
  always_comb begin
    vec_next = alloc_vec;
    if (grant)   vec_next[fifo[head]]    = 1'b1;
    if (free_ok) vec_next[bus.retire_id] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) fifo[i] <= 4'((i + RESET_FREE_BASE) % 16);
      head         <= 4'd0;
      tail         <= RESET_TAIL;
      count        <= RESET_CNT;
      alloc_vec    <= RESET_VEC;
      overflow_err <= 1'b0;
      dup_free_err <= 1'b0;
    end else begin
      dup_free_err <= dup_drop;
      if (bus.retire_transmit && full) overflow_err <= 1'b1;
      if (grant) head <= head + 4'd1;
      if (free_ok) begin
        fifo[tail] <= bus.retire_id;
        tail       <= tail + 4'd1;
      end
      case ({grant, free_ok})
        2'b10:   count <= count - 5'd1;
        2'b01:   count <= count + 5'd1;
        default: count <= count;
      endcase
      alloc_vec <= vec_next;
    end
  end

  // No same-cycle bypass: a freed id only shows up once it sits in the FIFO.
  assign bus.alloc_valid  = (count != 5'd0);
  assign bus.alloc_id     = fifo[head];
  assign bus.free_count   = count;
  assign bus.alloc_vec    = alloc_vec;
  assign bus.overflow_err = overflow_err;
  assign bus.dup_free_err = dup_free_err;

endmodule

// File: tb/tb_prf_freelist.sv
// Directed bench for prf_freelist: queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_prf_freelist;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  prf_freelist_if bus();

  prf_freelist #(.RESET_FREE_BASE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          free_q[$];
  logic [15:0] m_vec;
  bit          m_ovf;
  bit          m_dup;
  bit          m_live = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference behaviour: free ids are a plain queue, allocated ids a bitmap.
  task automatic model_step();
    bit grant, accept, dup_next;
    int gid;
    if (rst) begin
      free_q.delete();
      for (int i = 8; i < 16; i++) free_q.push_back(i);
      m_vec  = 16'h00FF;
      m_ovf  = 1'b0;
      m_dup  = 1'b0;
      m_live = 1'b1;
    end else begin
      grant    = bus.alloc_req && (free_q.size() != 0);
      gid      = grant ? free_q[0] : 0;
      accept   = bus.retire_transmit && (free_q.size() < 16);
      dup_next = 1'b0;
`ifdef PRF_FREELIST_DUP_CHECK_EN
      if (accept && !m_vec[bus.retire_id]) begin
        accept   = 1'b0;
        dup_next = 1'b1;
      end
`endif
      if (bus.retire_transmit && free_q.size() == 16) m_ovf = 1'b1;
      if (grant) begin
        void'(free_q.pop_front());
        m_vec[gid] = 1'b1;
      end
      if (accept) begin
        free_q.push_back(int'(bus.retire_id));
        m_vec[bus.retire_id] = 1'b0;
      end
      m_dup = dup_next;
    end
  endtask

  task automatic cyc(input bit r, input bit a, input bit t, input logic [3:0] id);
    rst                 = r;
    bus.alloc_req       = a;
    bus.retire_transmit = t;
    bus.retire_id       = id;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("m_valid", 32'(bus.alloc_valid), 32'(free_q.size() != 0));
      if (free_q.size() != 0) chk("m_id", 32'(bus.alloc_id), 32'(free_q[0]));
      chk("m_count", 32'(bus.free_count), 32'(free_q.size()));
      chk("m_vec", 32'(bus.alloc_vec), 32'(m_vec));
      chk("m_ovf", 32'(bus.overflow_err), 32'(m_ovf));
      chk("m_dup", 32'(bus.dup_free_err), 32'(m_dup));
    end
  end

  task automatic chk_reset_state(input string tag);
    @(negedge clk);
    chk({tag, "_count"}, 32'(bus.free_count), 32'd8);
    chk({tag, "_valid"}, 32'(bus.alloc_valid), 32'd1);
    chk({tag, "_id"},    32'(bus.alloc_id), 32'd8);
    chk({tag, "_vec"},   32'(bus.alloc_vec), 32'h00FF);
    chk({tag, "_ovf"},   32'(bus.overflow_err), 32'd0);
    chk({tag, "_dup"},   32'(bus.dup_free_err), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.alloc_req = 1'b0;
    bus.retire_transmit = 1'b0;
    bus.retire_id = 4'd0;

    // Reset state
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    chk_reset_state("rst");

    // Drain: ids 8..15 in order, ninth request ignored
    cyc(1'b0, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    chk("drain_id1", 32'(bus.alloc_id), 32'd9);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    chk("drain_valid", 32'(bus.alloc_valid), 32'd0);
    chk("drain_count", 32'(bus.free_count), 32'd0);
    chk("drain_vec", 32'(bus.alloc_vec), 32'hFFFF);

    // Empty: free 3 with a request -> no grant, visible next cycle
    cyc(1'b0, 1'b1, 1'b1, 4'd3);
    @(negedge clk);
    chk("nobyp_valid", 32'(bus.alloc_valid), 32'd1);
    chk("nobyp_id", 32'(bus.alloc_id), 32'd3);
    chk("nobyp_vec", 32'(bus.alloc_vec), 32'hFFF7);
    chk("nobyp_count", 32'(bus.free_count), 32'd1);

    // Fill to 16 with wrap, then overflow
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 1; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 4'(i));
    cyc(1'b0, 1'b0, 1'b1, 4'd0);
    @(negedge clk);
    chk("full_count", 32'(bus.free_count), 32'd16);
    chk("full_vec", 32'(bus.alloc_vec), 32'h0000);
    chk("full_id", 32'(bus.alloc_id), 32'd8);
    cyc(1'b0, 1'b0, 1'b1, 4'd5);
    idle();
    idle();
    @(negedge clk);
    chk("ovf_flag", 32'(bus.overflow_err), 32'd1);
    chk("ovf_count", 32'(bus.free_count), 32'd16);
    // Wrapped order: 8..15 then 1..7 then 0
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    chk("wrap_id", 32'(bus.alloc_id), 32'd2);

    // Free of a never-allocated id
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b1, 4'd12);
    @(negedge clk);
`ifdef PRF_FREELIST_DUP_CHECK_EN
    chk("dup_pulse", 32'(bus.dup_free_err), 32'd1);
    chk("dup_count", 32'(bus.free_count), 32'd8);
    idle();
    @(negedge clk);
    chk("dup_clear", 32'(bus.dup_free_err), 32'd0);
`else
    chk("nodup_count", 32'(bus.free_count), 32'd9);
    chk("nodup_flag", 32'(bus.dup_free_err), 32'd0);
`endif

    // Same-id grant and free
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 1'b1, 4'd8);
    @(negedge clk);
`ifndef PRF_FREELIST_DUP_CHECK_EN
    chk("same_vec", 32'(bus.alloc_vec), 32'h00FF);
    chk("same_count", 32'(bus.free_count), 32'd8);
`endif

    // Grant plus free of a different id: count unchanged
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 1'b1, 4'd0);
    @(negedge clk);
    chk("both_count", 32'(bus.free_count), 32'd8);
    chk("both_vec", 32'(bus.alloc_vec), 32'h01FE);
    chk("both_id", 32'(bus.alloc_id), 32'd9);

    // Reset wins over same-cycle grant and free
    cyc(1'b0, 1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b1, 1'b1, 4'd2);
    chk_reset_state("rstpri");
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
